dec_mtrx_slew: RTL and testbench
================================

Name: dec_mtrx_slew

Overview:
- Parametrised next-generation capacitor-matrix decoder.
- Converts a binary matrix code plus offset into row/column thermometer controls (col_on/col_off/row_p/row_n) and a binary band code into a band thermometer.
- Adds registered outputs, slew-limited code stepping and a band-change settle hold, so the cap array never takes large glitchy jumps.
- Sits between the CSR/loop-filter code source and the cap-array drivers.

Parameters:
ROWS, 16, matrix rows.
COLS, 16, matrix columns; ROWS*COLS must be a power of two.
MTRX_W, 8, matrix code width; equals log2(ROWS*COLS).
OS_W, 2, offset (os_bin) width.
BAND_W, 8, band code width.
BAND_N, 32, band thermometer width.
MAX_STEP, 4, maximum code change per cycle (>=1).
BAND_SETTLE, 8, hold cycles after a band change (>=1).

Ports:
dec_clk  in  1  clock, rising edge.
dec_rst_n  in  1  synchronous active-low reset.
csr_dec_en  in  1  decoder enable.
s_mtrx  in  MTRX_W  matrix code.
os_bin  in  OS_W  unsigned code offset.
s_band  in  BAND_W  band code.
col_on  out  COLS  column thermometer.
col_off  out  COLS  bitwise inverse of col_on.
row_p  out  ROWS  rows fully or partially on.
row_n  out  ROWS  rows fully on.
band_thrm  out  BAND_N  band thermometer.
dec_code  out  MTRX_W  current applied code.
dec_settled  out  1  applied code equals target and state is TRACK.
dec_busy  out  1  high in BAND_HOLD.

Behaviour:
Reset (dec_rst_n=0 at an edge):
- Register values: state=IDLE, cur_code=0, tgt_code=0, cur_band=0, tgt_band=0, hold_cnt=0.
- Outputs: col_on=0, col_off=all ones, row_p=1 (bit0 only), row_n=0, band_thrm=0, dec_code=0, dec_settled=0, dec_busy=0.
- Reset takes priority over everything, including mid-ramp and mid-hold.

Input stage, each edge with csr_dec_en=1:
- tgt_code <= min(s_mtrx + os_bin, 2^MTRX_W - 1), computed at MTRX_W+1 bits then saturated.
- tgt_band <= s_band.

Decode of code k (the same function is used for every output register):
- r = k / COLS, c = k % COLS.
- row_n[i] = (i < r); row_p[i] = (i <= r); col_on[j] = (j < c); col_off = ~col_on.
- Unit (i,j) is on iff row_n[i] | (row_p[i] & col_on[j]); the on-count equals k.
- band_thrm[i] = (i < min(cur_band, BAND_N)); band codes >= BAND_N saturate to all ones.

All outputs are registered. Each edge computes next cur_code/cur_band and loads their decodes, so the outputs always match dec_code and cur_band in the same cycle.

FSM:
- IDLE
  - csr_dec_en=1 and tgt_band==cur_band -> TRACK.
  - csr_dec_en=1 and tgt_band!=cur_band -> BAND_HOLD.
  - Otherwise stay. Outputs hold.
- TRACK
  - Each edge: if tgt_code > cur_code, cur_code += min(tgt_code - cur_code, MAX_STEP); if less, subtract likewise; if equal, hold.
  - tgt_band != cur_band -> BAND_HOLD. Band check has priority over stepping; cur_code is frozen on that edge.
  - csr_dec_en=0 -> IDLE, with cur_code frozen.
- BAND_HOLD
  - Entry edge: cur_band <= tgt_band, hold_cnt <= BAND_SETTLE-1, cur_code frozen.
  - Each later edge: hold_cnt decrements. At hold_cnt==0 -> TRACK.
  - A new band change during hold reloads cur_band and hold_cnt (restart).
  - Target code changes during hold are captured but not applied until TRACK.
  - csr_dec_en=0 during hold: the hold completes, then the FSM goes to IDLE.

Flags and latency:
- dec_settled = (state==TRACK) & (cur_code==tgt_code), registered.
- dec_busy = (state==BAND_HOLD).
- Latency: an input change sampled at edge N gives its first output change at edge N+1.
- Full-scale ramp takes ceil((2^MTRX_W - 1)/MAX_STEP) cycles.

Test Plan:
1. Reset: hold dec_rst_n=0 for 2 edges with s_mtrx=200 -> col_on=0, col_off=16'hFFFF, row_p=16'h0001, row_n=0, band_thrm=0, dec_code=0.
2. Ramp: en=1, s_band=0, os_bin=0, s_mtrx 0->37 -> dec_code 4,8,...,36,37 on consecutive edges. At 37: row_n=16'h0003, row_p=16'h0007, col_on=16'h001F, col_off=16'hFFE0, and dec_settled=1 the next cycle.
3. Saturation: s_mtrx=254, os_bin=3 -> final dec_code=255, row_n=16'h7FFF, row_p=16'hFFFF, col_on=16'h7FFF, col_off=16'h8000. Sweep n=0..255 with os_bin=0 and check that the on-count equals n at settle.
4. Band change mid-ramp: s_band 10->12 while ramping 0->100 -> dec_code frozen for 8 cycles, dec_busy=1, band_thrm goes 32'h000003FF->32'h00000FFF, then the ramp resumes at +4 per cycle.
5. Disable/reset mid-op: drop csr_dec_en during the ramp -> outputs hold and dec_settled=0; re-enable -> ramp resumes from the held code. Assert dec_rst_n=0 mid-hold -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/dec_mtrx_slew.sv
// Capacitor-matrix decoder: offset-saturated matrix code to row/column thermometers,
// binary band code to band thermometer, with slew-limited stepping and band-settle hold.
module dec_mtrx_slew #(
    parameter int unsigned ROWS        = 16,
    parameter int unsigned COLS        = 16,
    parameter int unsigned MTRX_W      = 8,
    parameter int unsigned OS_W        = 2,
    parameter int unsigned BAND_W      = 8,
    parameter int unsigned BAND_N      = 32,
    parameter int unsigned MAX_STEP    = 4,
    parameter int unsigned BAND_SETTLE = 8
) (
    input  logic              dec_clk,
    input  logic              dec_rst_n,
    input  logic              csr_dec_en,
    input  logic [MTRX_W-1:0] s_mtrx,
    input  logic [OS_W-1:0]   os_bin,
    input  logic [BAND_W-1:0] s_band,
    output logic [COLS-1:0]   col_on,
    output logic [COLS-1:0]   col_off,
    output logic [ROWS-1:0]   row_p,
    output logic [ROWS-1:0]   row_n,
    output logic [BAND_N-1:0] band_thrm,
    output logic [MTRX_W-1:0] dec_code,
    output logic              dec_settled,
    output logic              dec_busy
);

    localparam int unsigned HC_W = (BAND_SETTLE > 1) ? $clog2(BAND_SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRACK     = 2'd1,
        S_BAND_HOLD = 2'd2
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [MTRX_W-1:0] r_cur_code, r_tgt_code, w_nxt_code;
    logic [MTRX_W-1:0] w_diff, w_step, w_sat;
    logic [MTRX_W:0]   w_sum;
    logic [BAND_W-1:0] r_cur_band, r_tgt_band, w_nxt_band;
    logic [HC_W-1:0]   r_hold_cnt, w_nxt_hold;
    logic              r_settled;
    logic [COLS-1:0]   r_col_on;
    logic [ROWS-1:0]   r_row_p, r_row_n;
    logic [BAND_N-1:0] r_band_thrm;

    function automatic logic [COLS-1:0] f_col_on(input logic [MTRX_W-1:0] k);
        logic [COLS-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < COLS; j++) v[j] = (32'(k) % COLS) > j;
        return v;
    endfunction

    function automatic logic [ROWS-1:0] f_row_n(input logic [MTRX_W-1:0] k);
        logic [ROWS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < ROWS; i++) v[i] = (32'(k) / COLS) > i;
        return v;
    endfunction

    function automatic logic [ROWS-1:0] f_row_p(input logic [MTRX_W-1:0] k);
        logic [ROWS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < ROWS; i++) v[i] = (32'(k) / COLS) >= i;
        return v;
    endfunction

    // Codes at or above BAND_N naturally give all ones.
    function automatic logic [BAND_N-1:0] f_band(input logic [BAND_W-1:0] b);
        logic [BAND_N-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < BAND_N; i++) v[i] = 32'(b) > i;
        return v;
    endfunction

    assign w_sum  = {1'b0, s_mtrx} + (MTRX_W+1)'(os_bin);
    assign w_sat  = w_sum[MTRX_W] ? '1 : w_sum[MTRX_W-1:0];
    assign w_diff = (r_tgt_code > r_cur_code) ? (r_tgt_code - r_cur_code)
                                              : (r_cur_code - r_tgt_code);
    assign w_step = (w_diff > MTRX_W'(MAX_STEP)) ? MTRX_W'(MAX_STEP) : w_diff;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_code  = r_cur_code;
        w_nxt_band  = r_cur_band;
        w_nxt_hold  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (csr_dec_en) begin
                    if (r_tgt_band != r_cur_band) begin
                        w_nxt_state = S_BAND_HOLD;
                        w_nxt_band  = r_tgt_band;
                        w_nxt_hold  = HC_W'(BAND_SETTLE - 1);
                    end else begin
                        w_nxt_state = S_TRACK;
                    end
                end
            end
            S_TRACK: begin
                if (!csr_dec_en) begin
                    w_nxt_state = S_IDLE;
                end else if (r_tgt_band != r_cur_band) begin
                    w_nxt_state = S_BAND_HOLD;
                    w_nxt_band  = r_tgt_band;
                    w_nxt_hold  = HC_W'(BAND_SETTLE - 1);
                end else if (r_tgt_code > r_cur_code) begin
                    w_nxt_code = r_cur_code + w_step;
                end else if (r_tgt_code < r_cur_code) begin
                    w_nxt_code = r_cur_code - w_step;
                end
            end
            S_BAND_HOLD: begin
                // A fresh band change restarts the settle window.
                if (r_tgt_band != r_cur_band) begin
                    w_nxt_band = r_tgt_band;
                    w_nxt_hold = HC_W'(BAND_SETTLE - 1);
                end else if (r_hold_cnt == '0) begin
                    w_nxt_state = csr_dec_en ? S_TRACK : S_IDLE;
                end else begin
                    w_nxt_hold = r_hold_cnt - 1'b1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge dec_clk) begin
        if (!dec_rst_n) begin
            r_state    <= S_IDLE;
            r_cur_code <= '0;
            r_cur_band <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cur_code <= w_nxt_code;
            r_cur_band <= w_nxt_band;
            r_hold_cnt <= w_nxt_hold;
        end
    end

    always_ff @(posedge dec_clk) begin
        if (!dec_rst_n) begin
            r_tgt_code <= '0;
            r_tgt_band <= '0;
        end else if (csr_dec_en) begin
            r_tgt_code <= w_sat;
            r_tgt_band <= s_band;
        end
    end

    // Decodes are taken from the next-state values so outputs track dec_code in the same cycle.
    always_ff @(posedge dec_clk) begin
        if (!dec_rst_n) begin
            r_col_on    <= '0;
            r_row_p     <= ROWS'(1);
            r_row_n     <= '0;
            r_band_thrm <= '0;
            r_settled   <= 1'b0;
        end else begin
            r_col_on    <= f_col_on(w_nxt_code);
            r_row_p     <= f_row_p(w_nxt_code);
            r_row_n     <= f_row_n(w_nxt_code);
            r_band_thrm <= f_band(w_nxt_band);
            r_settled   <= (r_state == S_TRACK) && (r_cur_code == r_tgt_code);
        end
    end

    assign col_on      = r_col_on;
    assign col_off     = ~r_col_on;
    assign row_p       = r_row_p;
    assign row_n       = r_row_n;
    assign band_thrm   = r_band_thrm;
    assign dec_code    = r_cur_code;
    assign dec_settled = r_settled;
    assign dec_busy    = (r_state == S_BAND_HOLD);

endmodule

// File: tb/tb_dec_mtrx_slew.sv
// Self-checking bench for dec_mtrx_slew: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_dec_mtrx_slew;

    localparam int MAX_STEP    = 4;
    localparam int BAND_SETTLE = 8;
    localparam int CODE_MAX    = 255;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [7:0]  mtrx;
    logic [1:0]  os;
    logic [7:0]  band;
    logic [15:0] col_on, col_off, row_p, row_n;
    logic [31:0] band_thrm;
    logic [7:0]  dec_code;
    logic        dec_settled, dec_busy;
    logic [105:0] w_act;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode 0=idle, 1=tracking, 2=band hold
    int m_mode, m_cur, m_tgt, m_band, m_tband, m_hold;
    bit m_settled;

    dec_mtrx_slew #(
        .ROWS(16), .COLS(16), .MTRX_W(8), .OS_W(2), .BAND_W(8),
        .BAND_N(32), .MAX_STEP(MAX_STEP), .BAND_SETTLE(BAND_SETTLE)
    ) dut (
        .dec_clk(clk), .dec_rst_n(rst_n), .csr_dec_en(en),
        .s_mtrx(mtrx), .os_bin(os), .s_band(band),
        .col_on(col_on), .col_off(col_off), .row_p(row_p), .row_n(row_n),
        .band_thrm(band_thrm), .dec_code(dec_code),
        .dec_settled(dec_settled), .dec_busy(dec_busy)
    );

    assign w_act = {col_on, col_off, row_p, row_n, band_thrm, dec_code, dec_settled, dec_busy};

    always #5 clk = ~clk;

    function automatic void model_edge();
        int nm, nc, nb, nh, d;
        bit st;
        if (!rst_n) begin
            m_mode = 0; m_cur = 0; m_tgt = 0; m_band = 0; m_tband = 0; m_hold = 0;
            m_settled = 1'b0;
            return;
        end
        st = (m_mode == 1) && (m_cur == m_tgt);
        nm = m_mode; nc = m_cur; nb = m_band; nh = m_hold;
        if (m_mode == 0) begin
            if (en) begin
                if (m_tband != m_band) begin nm = 2; nb = m_tband; nh = BAND_SETTLE - 1; end
                else nm = 1;
            end
        end else if (m_mode == 1) begin
            if (!en) nm = 0;
            else if (m_tband != m_band) begin nm = 2; nb = m_tband; nh = BAND_SETTLE - 1; end
            else begin
                d = m_tgt - m_cur;
                if (d > MAX_STEP) d = MAX_STEP;
                if (d < -MAX_STEP) d = -MAX_STEP;
                nc = m_cur + d;
            end
        end else begin
            if (m_tband != m_band) begin nb = m_tband; nh = BAND_SETTLE - 1; end
            else if (m_hold == 0) nm = en ? 1 : 0;
            else nh = m_hold - 1;
        end
        if (en) begin
            m_tgt = int'(mtrx) + int'(os);
            if (m_tgt > CODE_MAX) m_tgt = CODE_MAX;
            m_tband = int'(band);
        end
        m_mode = nm; m_cur = nc; m_band = nb; m_hold = nh; m_settled = st;
    endfunction

    function automatic logic [105:0] exp_all();
        int r, c, nb;
        logic [15:0] co, rn, rp;
        logic [63:0] t;
        r  = m_cur / 16;
        c  = m_cur % 16;
        co = 16'((32'd1 << c) - 32'd1);
        rn = 16'((32'd1 << r) - 32'd1);
        rp = 16'((32'd2 << r) - 32'd1);
        nb = (m_band < 32) ? m_band : 32;
        t  = (64'd1 << nb) - 64'd1;
        return {co, ~co, rp, rn, t[31:0], 8'(m_cur), m_settled, (m_mode == 2)};
    endfunction

    function automatic int on_count();
        int n;
        n = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                if (row_n[i] | (row_p[i] & col_on[j])) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mtrx = 8'd200; os = 2'd0; band = 8'd0;
        tick(); tick();
        n_total++;
        if (w_act !== {16'h0, 16'hFFFF, 16'h0001, 16'h0, 32'h0, 8'h0, 1'b0, 1'b0})
            $display("FAIL reset_literal: got %h required %h", w_act,
                     {16'h0, 16'hFFFF, 16'h0001, 16'h0, 32'h0, 8'h0, 1'b0, 1'b0});
        else n_pass++;
        n_total++;
        if (w_act !== exp_all()) $display("FAIL reset_model: got %h required %h", w_act, exp_all());
        else n_pass++;
    endtask

    task automatic test_ramp();
        rst_n = 1'b1; en = 1'b1; band = 8'd0; os = 2'd0; mtrx = 8'd37;
        tick();
        n_total++;
        if (dec_code !== 8'd0) $display("FAIL ramp_capture: got %0d required 0", dec_code);
        else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_total++;
            if (dec_code !== 8'(4 * k) || w_act !== exp_all())
                $display("FAIL ramp_step%0d: got %0d (%h) required %0d (%h)", k, dec_code, w_act, 4 * k, exp_all());
            else n_pass++;
        end
        tick();
        n_total++;
        if ({dec_code, row_n, row_p, col_on, col_off, dec_settled} !==
            {8'd37, 16'h0003, 16'h0007, 16'h001F, 16'hFFE0, 1'b0})
            $display("FAIL ramp_37: got code=%0d rn=%h rp=%h con=%h coff=%h st=%b required 37 0003 0007 001f ffe0 0",
                     dec_code, row_n, row_p, col_on, col_off, dec_settled);
        else n_pass++;
        tick();
        n_total++;
        if (dec_settled !== 1'b1 || dec_code !== 8'd37)
            $display("FAIL ramp_settled: got st=%b code=%0d required 1 37", dec_settled, dec_code);
        else n_pass++;
    endtask

    task automatic test_saturation();
        mtrx = 8'd254; os = 2'd3;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_total++;
            if (w_act !== exp_all()) $display("FAIL sat_ramp%0d: got %h required %h", i, w_act, exp_all());
            else n_pass++;
        end
        n_total++;
        if ({dec_code, row_n, row_p, col_on, col_off, dec_settled} !==
            {8'd255, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1})
            $display("FAIL sat_255: got code=%0d rn=%h rp=%h con=%h coff=%h st=%b required 255 7fff ffff 7fff 8000 1",
                     dec_code, row_n, row_p, col_on, col_off, dec_settled);
        else n_pass++;
        os = 2'd0; mtrx = 8'd0;
        for (int i = 0; i < 66; i++) tick();
        n_total++;
        if (w_act !== exp_all() || dec_code !== 8'd0)
            $display("FAIL sat_down: got %h required %h", w_act, exp_all());
        else n_pass++;
        for (int n = 0; n < 256; n++) begin
            mtrx = 8'(n);
            tick(); tick(); tick();
            n_total++;
            if (on_count() !== n || dec_settled !== 1'b1)
                $display("FAIL sweep_count: got count=%0d st=%b required %0d 1", on_count(), dec_settled, n);
            else n_pass++;
        end
    endtask

    task automatic test_band_change();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; en = 1'b1; band = 8'd10; mtrx = 8'd0; os = 2'd0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_total++;
            if (w_act !== exp_all()) $display("FAIL band_init%0d: got %h required %h", i, w_act, exp_all());
            else n_pass++;
        end
        n_total++;
        if (band_thrm !== 32'h000003FF || dec_busy !== 1'b0)
            $display("FAIL band_10: got thrm=%h busy=%b required 000003ff 0", band_thrm, dec_busy);
        else n_pass++;
        mtrx = 8'd100;
        tick(); tick(); tick();
        n_total++;
        if (dec_code !== 8'd8) $display("FAIL band_preramp: got %0d required 8", dec_code);
        else n_pass++;
        band = 8'd12;
        tick();
        n_total++;
        if (dec_code !== 8'd12 || dec_busy !== 1'b0)
            $display("FAIL band_capture: got code=%0d busy=%b required 12 0", dec_code, dec_busy);
        else n_pass++;
        tick();
        n_total++;
        if (dec_code !== 8'd12 || dec_busy !== 1'b1 || band_thrm !== 32'h00000FFF)
            $display("FAIL band_entry: got code=%0d busy=%b thrm=%h required 12 1 00000fff", dec_code, dec_busy, band_thrm);
        else n_pass++;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_total++;
            if (dec_code !== 8'd12 || dec_busy !== 1'b1 || w_act !== exp_all())
                $display("FAIL band_hold%0d: got code=%0d busy=%b required 12 1", i, dec_code, dec_busy);
            else n_pass++;
        end
        tick();
        n_total++;
        if (dec_code !== 8'd12 || dec_busy !== 1'b0)
            $display("FAIL band_exit: got code=%0d busy=%b required 12 0", dec_code, dec_busy);
        else n_pass++;
        tick();
        n_total++;
        if (dec_code !== 8'd16 || w_act !== exp_all())
            $display("FAIL band_resume: got code=%0d required 16", dec_code);
        else n_pass++;
    endtask

    task automatic test_disable_reset();
        tick(); tick(); tick();
        n_total++;
        if (dec_code !== 8'd28) $display("FAIL dis_pre: got %0d required 28", dec_code);
        else n_pass++;
        en = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (dec_code !== 8'd28 || dec_settled !== 1'b0 || w_act !== exp_all())
                $display("FAIL dis_hold%0d: got code=%0d st=%b required 28 0", i, dec_code, dec_settled);
            else n_pass++;
        end
        en = 1'b1;
        tick(); tick();
        n_total++;
        if (dec_code !== 8'd32 || w_act !== exp_all())
            $display("FAIL dis_resume: got code=%0d required 32", dec_code);
        else n_pass++;
        band = 8'd20;
        tick(); tick(); tick();
        n_total++;
        if (dec_busy !== 1'b1) $display("FAIL rst_midhold_busy: got %b required 1", dec_busy);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_total++;
        if (w_act !== {16'h0, 16'hFFFF, 16'h0001, 16'h0, 32'h0, 8'h0, 1'b0, 1'b0})
            $display("FAIL rst_midhold: got %h required %h", w_act,
                     {16'h0, 16'hFFFF, 16'h0001, 16'h0, 32'h0, 8'h0, 1'b0, 1'b0});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        band = 8'd0;
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mtrx = 8'($urandom);
            os = 2'($urandom);
            if ($urandom_range(0, 39) == 0) band = 8'($urandom_range(0, 40));
            tick();
            n_total++;
            if (w_act !== exp_all()) $display("FAIL random%0d: got %h required %h", i, w_act, exp_all());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mtrx = '0; os = '0; band = '0;
        m_mode = 0; m_cur = 0; m_tgt = 0; m_band = 0; m_tband = 0; m_hold = 0; m_settled = 1'b0;
        test_reset();
        test_ramp();
        test_saturation();
        test_band_change();
        test_disable_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
